// File: rtl/trapezoid_bank_seq_if.sv
// Request/result bundle between the input scaling stage, the trapezoid
// membership bank and the rule engine.
interface trapezoid_bank_seq_if #(
    parameter int DATA_W = 8,
    parameter int MU_W   = 16,
    parameter int N_MF   = 4
) ();
    logic                     start;
    logic [DATA_W-1:0]        x;
    logic [N_MF*DATA_W-1:0]   a_i;
    logic [N_MF*DATA_W-1:0]   b_i;
    logic [N_MF*DATA_W-1:0]   c_i;
    logic [N_MF*DATA_W-1:0]   d_i;
    logic                     busy;
    logic                     done;
    logic [N_MF*MU_W-1:0]     mu_o;
    logic [N_MF-1:0]          err_o;

    // Requester side: issues the crisp input and MF breakpoints.
    modport master (
        output start, x, a_i, b_i, c_i, d_i,
        input  busy, done, mu_o, err_o
    );

    // Evaluator side.
    modport slave (
        input  start, x, a_i, b_i, c_i, d_i,
        output busy, done, mu_o, err_o
    );
endinterface

// File: rtl/trapezoid_bank_seq.sv
// Sequential trapezoidal/triangular membership bank. One MF is classified
// per cycle; sloped MFs go through a single shared restoring divider that
// produces one quotient bit per cycle. The μ vector is published atomically.
module trapezoid_bank_seq #(
    parameter int DATA_W = 8,
    parameter int MU_W   = 16,
    parameter int N_MF   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    trapezoid_bank_seq_if.slave  bus
);
    localparam int IDX_W = (N_MF > 1) ? $clog2(N_MF) : 1;
    localparam int CNT_W = $clog2(MU_W);
    localparam int NUM_W = DATA_W + 1;
    localparam int REM_W = DATA_W + 2;
    localparam int Q_W   = MU_W - 1;

    localparam logic [MU_W-1:0]  MU_ONE   = {1'b0, {(MU_W-1){1'b1}}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MU_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_DIVIDE,
        ST_FINISH
    } state_t;

    state_t state_reg, state_next;

    // Unpacked views of the live breakpoint buses.
    logic signed [DATA_W-1:0] a_in [N_MF];
    logic signed [DATA_W-1:0] b_in [N_MF];
    logic signed [DATA_W-1:0] c_in [N_MF];
    logic signed [DATA_W-1:0] d_in [N_MF];

    // Snapshot of the request taken when start is accepted.
    logic signed [DATA_W-1:0] x_reg;
    logic signed [DATA_W-1:0] a_reg [N_MF];
    logic signed [DATA_W-1:0] b_reg [N_MF];
    logic signed [DATA_W-1:0] c_reg [N_MF];
    logic signed [DATA_W-1:0] d_reg [N_MF];

    // Working and published results.
    logic [MU_W-1:0]  mu_work_reg [N_MF];
    logic [N_MF-1:0]  err_work_reg;
    logic [MU_W-1:0]  mu_o_reg [N_MF];
    logic [N_MF-1:0]  err_o_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [IDX_W-1:0] idx_reg;

    // Shared divider state.
    logic [REM_W-1:0] rem_reg;
    logic [NUM_W-1:0] den_reg;
    logic [Q_W-1:0]   quo_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Classifier results for the MF at idx_reg.
    logic signed [DATA_W-1:0] a_sel, b_sel, c_sel, d_sel;
    logic [NUM_W-1:0] ext_x, ext_a, ext_b, ext_c, ext_d;
    logic             cls_err;
    logic             cls_div;
    logic [MU_W-1:0]  cls_mu;
    logic [NUM_W-1:0] num_calc;
    logic [NUM_W-1:0] den_calc;

    // Divider step results.
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] den_ext;
    logic             rem_ge;
    logic [REM_W-1:0] rem_nx;
    logic [Q_W-1:0]   quo_nx;

    // FSM strobes to the datapath.
    logic load_req;
    logic cls_write;
    logic div_load;
    logic div_step;
    logic div_write;
    logic idx_inc;
    logic fin;

    logic last_mf;

    generate
        for (genvar gi = 0; gi < N_MF; gi++) begin : g_unpack
            assign a_in[gi] = bus.a_i[gi*DATA_W +: DATA_W];
            assign b_in[gi] = bus.b_i[gi*DATA_W +: DATA_W];
            assign c_in[gi] = bus.c_i[gi*DATA_W +: DATA_W];
            assign d_in[gi] = bus.d_i[gi*DATA_W +: DATA_W];
            assign bus.mu_o[gi*MU_W +: MU_W] = mu_o_reg[gi];
        end
    endgenerate

    assign bus.err_o = err_o_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;

    assign a_sel   = a_reg[idx_reg];
    assign b_sel   = b_reg[idx_reg];
    assign c_sel   = c_reg[idx_reg];
    assign d_sel   = d_reg[idx_reg];
    assign last_mf = (idx_reg == IDX_LAST);

    // Region test for the current MF; first matching region wins.
    always_comb begin
        ext_x    = {x_reg[DATA_W-1], x_reg};
        ext_a    = {a_sel[DATA_W-1], a_sel};
        ext_b    = {b_sel[DATA_W-1], b_sel};
        ext_c    = {c_sel[DATA_W-1], c_sel};
        ext_d    = {d_sel[DATA_W-1], d_sel};
        cls_err  = 1'b0;
        cls_div  = 1'b0;
        cls_mu   = '0;
        num_calc = '0;
        den_calc = '0;
        if (!((a_sel <= b_sel) && (b_sel <= c_sel) && (c_sel <= d_sel))) begin
            cls_err = 1'b1;
        end else if ((x_reg <= a_sel) || (x_reg >= d_sel)) begin
            cls_mu = '0;
        end else if ((x_reg >= b_sel) && (x_reg <= c_sel)) begin
            cls_mu = MU_ONE;
        end else if (x_reg < b_sel) begin
            // Rising edge: differences are positive and fit DATA_W+1 bits.
            cls_div  = 1'b1;
            num_calc = ext_x - ext_a;
            den_calc = ext_b - ext_a;
        end else begin
            cls_div  = 1'b1;
            num_calc = ext_d - ext_x;
            den_calc = ext_d - ext_c;
        end
    end

    // One restoring-division step; num<den keeps rem below 2*den.
    always_comb begin
        rem_sh  = rem_reg << 1;
        den_ext = {1'b0, den_reg};
        rem_ge  = (rem_sh >= den_ext);
        rem_nx  = rem_ge ? (rem_sh - den_ext) : rem_sh;
        quo_nx  = (quo_reg << 1) | Q_W'(rem_ge);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next = state_reg;
        load_req   = 1'b0;
        cls_write  = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;
        div_write  = 1'b0;
        idx_inc    = 1'b0;
        fin        = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    load_req   = 1'b1;
                    state_next = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (cls_div) begin
                    div_load   = 1'b1;
                    state_next = ST_DIVIDE;
                end else begin
                    cls_write = 1'b1;
                    if (last_mf) begin
                        state_next = ST_FINISH;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_DIVIDE: begin
                div_step = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    div_write = 1'b1;
                    if (last_mf) begin
                        state_next = ST_FINISH;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = ST_CLASSIFY;
                    end
                end
            end
            ST_FINISH: begin
                fin        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Snapshot, working results, divider and published outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg        <= '0;
            err_work_reg <= '0;
            err_o_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            idx_reg      <= '0;
            rem_reg      <= '0;
            den_reg      <= '0;
            quo_reg      <= '0;
            cnt_reg      <= '0;
            for (int k = 0; k < N_MF; k++) begin
                a_reg[k]       <= '0;
                b_reg[k]       <= '0;
                c_reg[k]       <= '0;
                d_reg[k]       <= '0;
                mu_work_reg[k] <= '0;
                mu_o_reg[k]    <= '0;
            end
        end else begin
            done_reg <= fin;
            if (load_req) begin
                x_reg        <= bus.x;
                err_work_reg <= '0;
                idx_reg      <= '0;
                busy_reg     <= 1'b1;
                for (int k = 0; k < N_MF; k++) begin
                    a_reg[k]       <= a_in[k];
                    b_reg[k]       <= b_in[k];
                    c_reg[k]       <= c_in[k];
                    d_reg[k]       <= d_in[k];
                    mu_work_reg[k] <= '0;
                end
            end
            if (cls_write) begin
                mu_work_reg[idx_reg]  <= cls_mu;
                err_work_reg[idx_reg] <= cls_err;
            end
            if (div_load) begin
                rem_reg <= {1'b0, num_calc};
                // Region tests already ensure den>0; guard against a zero divisor anyway.
                den_reg <= (den_calc == '0) ? NUM_W'(1) : den_calc;
                quo_reg <= '0;
                cnt_reg <= '0;
            end
            if (div_step) begin
                rem_reg <= rem_nx;
                quo_reg <= quo_nx;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (div_write) begin
                mu_work_reg[idx_reg] <= {1'b0, quo_nx};
            end
            if (idx_inc) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
            if (fin) begin
                busy_reg  <= 1'b0;
                err_o_reg <= err_work_reg;
                for (int k = 0; k < N_MF; k++) begin
                    mu_o_reg[k] <= mu_work_reg[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_trapezoid_bank_seq.sv
// Directed bench for trapezoid_bank_seq with hand-computed μ values and latencies.
module tb_trapezoid_bank_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    trapezoid_bank_seq_if #(.DATA_W(8), .MU_W(16), .N_MF(4)) bus ();

    trapezoid_bank_seq #(.DATA_W(8), .MU_W(16), .N_MF(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mu_of(input int k);
        return bus.mu_o[k*16 +: 16];
    endfunction

    task automatic set_mf(input int k, input logic signed [7:0] a, input logic signed [7:0] b,
                          input logic signed [7:0] c, input logic signed [7:0] d);
        bus.a_i[k*8 +: 8] = a;
        bus.b_i[k*8 +: 8] = b;
        bus.c_i[k*8 +: 8] = c;
        bus.d_i[k*8 +: 8] = d;
    endtask

    // One request: latency counted in edges from the start-sampling edge to done.
    task automatic run_req(input logic signed [7:0] xv, output int lat);
        @(negedge clk);
        bus.x     = xv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1'b1);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", bus.done, 1'b1);
        $display("req x=%0d latency=%0d mu=%h err=%b", xv, lat, bus.mu_o, bus.err_o);
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    initial begin
        int lat;
        int dcount;
        int dlat;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        bus.c_i   = '0;
        bus.d_i   = '0;
        set_mf(0, -40, -20, -20, 0);
        set_mf(1, 0, 10, 20, 30);
        set_mf(2, 40, 50, 60, 70);
        set_mf(3, 40, 50, 60, 70);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_mu", bus.mu_o, 64'h0);
        chk("rst_err", bus.err_o, 4'h0);
        rst = 1'b0;

        // Triangle MF0, slope: 10/20 -> 0x4000, one slope plus three constants.
        run_req(-30, lat);
        chk("t1_lat", lat, 20);
        chk("t1_mu", bus.mu_o, 64'h0000_0000_0000_4000);
        chk("t1_err", bus.err_o, 4'h0);

        // MF1 plateau and feet; all four MFs constant.
        run_req(15, lat);
        chk("t2_lat", lat, 5);
        chk("t2_mu1_15", mu_of(1), 16'h7FFF);
        run_req(0, lat);
        chk("t2_mu1_0", mu_of(1), 16'h0000);
        chk("t2_mu0_0", mu_of(0), 16'h0000);
        run_req(30, lat);
        chk("t2_mu1_30", mu_of(1), 16'h0000);
        run_req(10, lat);
        chk("t2_mu1_10", mu_of(1), 16'h7FFF);
        run_req(20, lat);
        chk("t2_mu1_20", mu_of(1), 16'h7FFF);

        // MF1 slopes.
        run_req(21, lat);
        chk("t3_lat", lat, 20);
        chk("t3_mu1_21", mu_of(1), 16'd29491);
        run_req(25, lat);
        chk("t3_mu1_25", mu_of(1), 16'h4000);
        run_req(1, lat);
        chk("t3_mu1_1", mu_of(1), 16'd3276);

        // Full-range MF3.
        set_mf(3, -128, 127, 127, 127);
        run_req(126, lat);
        chk("t4_lat", lat, 20);
        chk("t4_mu3_126", mu_of(3), 16'd32639);
        run_req(-128, lat);
        chk("t4_mu3_m128", mu_of(3), 16'h0000);
        chk("t4_lat_m128", lat, 5);
        run_req(127, lat);
        chk("t4_mu3_127", mu_of(3), 16'h0000);

        // Invalid ordering on MF2.
        set_mf(3, 40, 50, 60, 70);
        set_mf(2, 10, 5, 20, 30);
        run_req(15, lat);
        chk("t5_lat", lat, 5);
        chk("t5_err", bus.err_o, 4'b0100);
        chk("t5_mu", bus.mu_o, 64'h0000_0000_7FFF_0000);
        set_mf(2, 40, 50, 60, 70);

        // Reset in the middle of a division.
        @(negedge clk);
        bus.x     = -30;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_done", bus.done, 1'b0);
        chk("t6_rst_mu", bus.mu_o, 64'h0);
        chk("t6_rst_err", bus.err_o, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // start held through busy with x changing: one request from the snapshot.
        @(negedge clk);
        bus.x     = -30;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        dcount = 0;
        dlat   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) bus.x = 15;
            if (i == 10) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (i == 19) chk("t6_busy_held", bus.busy, 1'b1);
            if (i == 20) chk("t6_busy_drop", bus.busy, 1'b0);
            if (bus.done) begin
                dcount++;
                if (dcount == 1) dlat = i;
            end
        end
        $display("held-start request done_count=%0d latency=%0d mu=%h", dcount, dlat, bus.mu_o);
        chk("t6_done_count", dcount, 1);
        chk("t6_lat", dlat, 20);
        chk("t6_mu0", mu_of(0), 16'h4000);

        // A fresh request is accepted after the previous done.
        run_req(15, lat);
        chk("t6_next_lat", lat, 5);
        chk("t6_next_mu1", mu_of(1), 16'h7FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
